// File: rtl/vx_issue_sched.sv
// vx_issue_sched: per-warp scoreboard check, round-robin issue select and a
// one-entry issued-instruction register with a stall counter.
// Optional build macro SCOREBOARD_WB_BYPASS_EN: a same-cycle writeback release
// is treated as not busy by the hazard check.

// Per-warp hazard check against that warp's row of the busy table.
module vx_issue_lane #(
  parameter int NR_BITS = 6
) (
  input  logic [2**NR_BITS-1:0] busy,
  input  logic [2**NR_BITS-1:0] rel,
  input  logic                  valid,
  input  logic                  wb,
  input  logic [4*NR_BITS-1:0]  regs,
  output logic                  eligible
);
  localparam int NR = 2**NR_BITS;

  logic [NR-1:0]      busy_eff;
  logic [NR_BITS-1:0] rs1, rs2, rs3, rd;

  assign {rd, rs3, rs2, rs1} = regs;
  // Register 0 is forced free so checks against it always pass.
  assign busy_eff = busy & ~rel & {{(NR-1){1'b1}}, 1'b0};

  // Eligible when no source is pending and, for writers, rd is not pending.
  always_comb begin
    eligible = valid & ~busy_eff[rs1] & ~busy_eff[rs2] & ~busy_eff[rs3]
             & ~(wb & busy_eff[rd]);
  end
endmodule

module vx_issue_sched #(
  parameter int NUM_WARPS = 4,
  parameter int NR_BITS   = 6
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_WARPS-1:0]           in_valid,
  input  logic [NUM_WARPS-1:0]           in_wb,
  input  logic [NUM_WARPS*4*NR_BITS-1:0] in_regs,
  output logic [NUM_WARPS-1:0]           in_ready,
  output logic                           out_valid,
  output logic [$clog2(NUM_WARPS)-1:0]   out_wis,
  input  logic                           out_ready,
  input  logic                           wb_valid,
  input  logic [$clog2(NUM_WARPS)-1:0]   wb_wis,
  input  logic [NR_BITS-1:0]             wb_rd,
  output logic [31:0]                    stall_cnt
);
  localparam int WIS_W = $clog2(NUM_WARPS);
  localparam int NR    = 2**NR_BITS;

  logic [NUM_WARPS-1:0][NR-1:0]        busy, busy_nxt, rel;
  logic [NUM_WARPS-1:0][4*NR_BITS-1:0] regs;
  logic [NUM_WARPS-1:0]                elig;
  logic [WIS_W-1:0]                    rr_ptr, gnt_idx, idx;
  logic                                gnt_found, take, fire;
  logic [NR_BITS-1:0]                  gnt_rd;

  assign regs = in_regs;

  genvar w;
  generate
    for (w = 0; w < NUM_WARPS; w++) begin : g_lane
`ifdef SCOREBOARD_WB_BYPASS_EN
      assign rel[w] = (wb_valid && wb_wis == WIS_W'(w)) ? (NR'(1) << wb_rd) : '0;
`else
      assign rel[w] = '0;
`endif
      vx_issue_lane #(.NR_BITS(NR_BITS)) u_lane (
        .busy     (busy[w]),
        .rel      (rel[w]),
        .valid    (in_valid[w]),
        .wb       (in_wb[w]),
        .regs     (regs[w]),
        .eligible (elig[w])
      );
    end
  endgenerate

  // Round-robin pick: first eligible warp at or after rr_ptr.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      idx = rr_ptr + WIS_W'(i);
      if (!gnt_found && elig[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  assign take     = !reset && (!out_valid || out_ready);
  assign fire     = take && gnt_found;
  assign in_ready = fire ? (NUM_WARPS'(1) << gnt_idx) : '0;
  assign gnt_rd   = regs[gnt_idx][4*NR_BITS-1 -: NR_BITS];

  // Busy table next value: release first, so a same-bit set wins.
  always_comb begin
    busy_nxt = busy;
    if (wb_valid) busy_nxt[wb_wis][wb_rd] = 1'b0;
    if (fire && in_wb[gnt_idx] && gnt_rd != '0) busy_nxt[gnt_idx][gnt_rd] = 1'b1;
  end

  // Scoreboard, issue register, rr pointer and stall counter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= '0;
      out_valid <= 1'b0;
      out_wis   <= '0;
      rr_ptr    <= '0;
      stall_cnt <= '0;
    end else begin
      busy <= busy_nxt;
      if (fire) begin
        out_valid <= 1'b1;
        out_wis   <= gnt_idx;
        rr_ptr    <= gnt_idx + 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (|in_valid && ~|in_ready) stall_cnt <= stall_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_vx_issue_sched.sv
// Bench for vx_issue_sched: cycle vectors, directed corner sequences and a
// randomized run against a behavioural scoreboard model.
module tb_vx_issue_sched;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  in_valid, in_wb;
  logic [95:0] in_regs;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [1:0]  out_wis;
  logic        out_ready;
  logic        wb_valid;
  logic [1:0]  wb_wis;
  logic [5:0]  wb_rd;
  logic [31:0] stall_cnt;

  int errors = 0;
  int checks = 0;

`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  vx_issue_sched #(.NUM_WARPS(4), .NR_BITS(6)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_wb(in_wb),
    .in_regs(in_regs), .in_ready(in_ready), .out_valid(out_valid),
    .out_wis(out_wis), .out_ready(out_ready), .wb_valid(wb_valid),
    .wb_wis(wb_wis), .wb_rd(wb_rd), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid = '0; in_wb = '0; in_regs = '0; out_ready = 1'b1;
    wb_valid = 1'b0; wb_wis = '0; wb_rd = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Cycle vector: inputs driven for one cycle, expected outputs before the edge.
  typedef struct {
    logic [3:0]  valid, wb;
    logic [23:0] regs0;   // warp0 {rd,rs3,rs2,rs1}
    logic        ordy, wbv;
    logic [5:0]  wbrd;
    logic [3:0]  rdy;
    logic        ov;
    logic [31:0] stl;
  } vec_t;
  vec_t vt[8];

  // Behavioural model state
  bit          m_busy[4][64];
  bit          m_ov;
  int          m_wis, m_ptr;
  int unsigned m_stall;

  function automatic int fld(int w, int k);
    logic [95:0] r;
    r = in_regs;
    return int'(r[w*24 + k*6 +: 6]);
  endfunction

  function automatic bit m_bsy(int w, int r);
    if (r == 0) return 1'b0;
    if (BYP && wb_valid && int'(wb_wis) == w && int'(wb_rd) == r) return 1'b0;
    return m_busy[w][r];
  endfunction

  function automatic bit m_elig(int w);
    if (!in_valid[w]) return 1'b0;
    if (m_bsy(w, fld(w,0)) || m_bsy(w, fld(w,1)) || m_bsy(w, fld(w,2))) return 1'b0;
    if (in_wb[w] && m_bsy(w, fld(w,3))) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    // warp0 only; wb releases always target warp0
    vt[0] = '{4'h1, 4'h1, {6'd5,6'd3,6'd2,6'd1}, 1'b1, 1'b0, 6'd0, 4'h1, 1'b0, 32'd0};
    vt[1] = '{4'h1, 4'h0, {6'd0,6'd0,6'd0,6'd5}, 1'b1, 1'b0, 6'd0, 4'h0, 1'b1, 32'd0};
    vt[2] = '{4'h1, 4'h0, {6'd0,6'd0,6'd0,6'd5}, 1'b1, 1'b1, 6'd5, {3'b0,BYP}, 1'b0, 32'd1};
    vt[3] = '{4'h1, 4'h0, {6'd0,6'd0,6'd0,6'd5}, 1'b1, 1'b0, 6'd0, 4'h1, BYP, BYP ? 32'd1 : 32'd2};
    vt[4] = '{4'h1, 4'h1, {6'd0,6'd0,6'd0,6'd0}, 1'b1, 1'b0, 6'd0, 4'h1, 1'b1, BYP ? 32'd1 : 32'd2};
    vt[5] = '{4'h1, 4'h0, {6'd0,6'd0,6'd0,6'd0}, 1'b1, 1'b0, 6'd0, 4'h1, 1'b1, BYP ? 32'd1 : 32'd2};
    vt[6] = '{4'h0, 4'h0, 24'd0,                 1'b1, 1'b0, 6'd0, 4'h0, 1'b1, BYP ? 32'd1 : 32'd2};
    vt[7] = '{4'h0, 4'h0, 24'd0,                 1'b1, 1'b0, 6'd0, 4'h0, 1'b0, BYP ? 32'd1 : 32'd2};

    do_reset();
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_out_wis", {30'b0, out_wis}, 32'd0);
    chk("reset_stall", stall_cnt, 32'd0);

    // Vector table: first issue, RAW on busy rd, release timing, rd=0 issue
    for (int i = 0; i < 8; i++) begin
      in_valid = vt[i].valid; in_wb = vt[i].wb; in_regs = {72'b0, vt[i].regs0};
      out_ready = vt[i].ordy; wb_valid = vt[i].wbv; wb_wis = 2'd0; wb_rd = vt[i].wbrd;
      #2;
      chk($sformatf("vec%0d_in_ready", i), {28'b0, in_ready}, {28'b0, vt[i].rdy});
      chk($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vt[i].ov});
      if (vt[i].ov) chk($sformatf("vec%0d_out_wis", i), {30'b0, out_wis}, 32'd0);
      chk($sformatf("vec%0d_stall", i), stall_cnt, vt[i].stl);
      @(posedge clk); #1;
    end

    // Round-robin over all four warps with continuous drain
    do_reset();
    in_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #2;
      chk($sformatf("rr%0d_in_ready", k), {28'b0, in_ready}, 32'd1 << (k % 4));
      @(posedge clk); #1;
    end
    chk("rr_stall_zero", stall_cnt, 32'd0);

    // Backpressure: held instruction stays put, stall counts up
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #2;
      chk($sformatf("bp%0d_in_ready", k), {28'b0, in_ready}, 32'd0);
      chk($sformatf("bp%0d_out_valid", k), {31'b0, out_valid}, 32'd1);
      chk($sformatf("bp%0d_out_wis", k), {30'b0, out_wis}, 32'd3);
      chk($sformatf("bp%0d_stall", k), stall_cnt, k);
      @(posedge clk); #1;
    end

    // Reset while holding an instruction with busy[0][5] pending
    out_ready = 1'b1; in_valid = 4'h1; in_wb = 4'h1; in_regs = {72'b0, 6'd5, 18'd0};
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 4'h0; in_wb = 4'h0;
    @(posedge clk); #1;
    chk("pre_rst_out_valid", {31'b0, out_valid}, 32'd1);
    reset = 1'b1; in_valid = 4'hF;
    #2;
    chk("rst_in_ready", {28'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 4'h1; out_ready = 1'b1; in_regs = {90'b0, 6'd5};
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_stall", stall_cnt, 32'd0);
    #1;
    chk("rst_busy_cleared", {28'b0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Randomized run against the model
    do_reset();
    foreach (m_busy[a, b]) m_busy[a][b] = 1'b0;
    m_ov = 1'b0; m_wis = 0; m_ptr = 0; m_stall = 0;
    for (int c = 0; c < 3000; c++) begin
      automatic int g = -1;
      automatic logic [3:0] exp_rdy = '0;
      reset = ($urandom_range(0, 99) == 0);
      in_valid = 4'($urandom); in_wb = 4'($urandom);
      for (int f = 0; f < 16; f++) in_regs[f*6 +: 6] = 6'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      wb_valid = ($urandom_range(0, 2) == 0);
      wb_wis = 2'($urandom); wb_rd = 6'($urandom_range(0, 7));
      #2;
      if (!reset && (!m_ov || out_ready)) begin
        for (int i = 0; i < 4; i++)
          if (g < 0 && m_elig((m_ptr + i) % 4)) g = (m_ptr + i) % 4;
      end
      if (g >= 0) exp_rdy = 4'(1 << g);
      chk("rnd_in_ready", {28'b0, in_ready}, {28'b0, exp_rdy});
      chk("rnd_out_valid", {31'b0, out_valid}, {31'b0, m_ov});
      if (m_ov) chk("rnd_out_wis", {30'b0, out_wis}, m_wis);
      chk("rnd_stall", stall_cnt, m_stall);
      @(posedge clk);
      if (reset) begin
        foreach (m_busy[a, b]) m_busy[a][b] = 1'b0;
        m_ov = 1'b0; m_wis = 0; m_ptr = 0; m_stall = 0;
      end else begin
        if (wb_valid) m_busy[wb_wis][wb_rd] = 1'b0;
        if (g >= 0) begin
          if (in_wb[g] && fld(g, 3) != 0) m_busy[g][fld(g, 3)] = 1'b1;
          m_ov = 1'b1; m_wis = g; m_ptr = (g + 1) % 4;
        end else if (out_ready) begin
          m_ov = 1'b0;
        end
        if (|in_valid && exp_rdy == 0) m_stall++;
      end
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vx_issue_sched.md
VX_ISSUE_SCHED -- requirements
Module: VX_issue_sched

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4: number of issue-slot warp queues; power of two, 2..16.
REQ-002 SHALL have parameter NR_BITS, default 6: register index width; 2**NR_BITS registers per warp.
REQ-003 SHALL have port clk  in  1: single clock.
REQ-004 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid  in  NUM_WARPS: per-warp decoded instruction available.
REQ-006 SHALL have port in_wb  in  NUM_WARPS: per-warp instruction writes rd.
REQ-007 SHALL have port in_regs  in  NUM_WARPS*4*NR_BITS: per-warp {rd,rs3,rs2,rs1}, warp 0 in the LSBs.
REQ-008 SHALL have port in_ready  out  NUM_WARPS: per-warp accept, one-hot or zero.
REQ-009 SHALL have port out_valid  out  1: issued-instruction register occupied.
REQ-010 SHALL have port out_wis  out  log2(NUM_WARPS): warp of the issued instruction.
REQ-011 SHALL have port out_ready  in  1: downstream accept.
REQ-012 SHALL have port wb_valid  in  1: writeback release request.
REQ-013 SHALL have port wb_wis / wb_rd  in  log2(NUM_WARPS) / NR_BITS: warp and register released.
REQ-014 SHALL have port stall_cnt  out  32: cycles with any in_valid high but no in_ready high.

Function
REQ-015 SHALL hold a busy table of NUM_WARPS x 2**NR_BITS bits, one bit per warp register.
REQ-016 Warp w SHALL be eligible when in_valid[w] and none of busy[w][rs1], busy[w][rs2], busy[w][rs3] is set, and, if in_wb[w], busy[w][rd] is not set (WAR/WAW).
REQ-017 Register index 0 SHALL never be busy: it is never set, and checks against it always pass.
REQ-018 SHALL select at most one eligible warp per cycle, round-robin, with priority starting at the warp after the last granted one.
REQ-019 The grant SHALL be taken only when the output register is empty or drains this cycle (out_valid && out_ready); in_ready[w] SHALL be high exactly for the granted warp under that condition.
REQ-020 On grant (in_valid[w] && in_ready[w]), the next edge SHALL load out_wis=w, set out_valid, and set busy[w][rd] if in_wb[w] and rd!=0.
REQ-021 Issue latency SHALL be 1 cycle from grant to out_valid; throughput SHALL be 1 per cycle under continuous out_ready.
REQ-022 out_valid && !out_ready SHALL hold out_valid and out_wis stable; out_valid && out_ready without a grant SHALL clear out_valid.
REQ-023 wb_valid SHALL clear busy[wb_wis][wb_rd] at the next edge.
REQ-024 Simultaneous set and clear of the same bit SHALL result in the bit set.
REQ-025 The round-robin pointer SHALL wrap from NUM_WARPS-1 to 0 and update only on a grant.
REQ-026 stall_cnt SHALL increment by 1 on each stall cycle and wrap from 0xFFFFFFFF to 0.

Reset
REQ-027 While reset is high, at the next clk edge: busy table all zero, out_valid=0, out_wis=0, round-robin pointer=0, stall_cnt=0.
REQ-028 in_ready SHALL be all zero while reset is high.
REQ-029 Reset mid-operation SHALL discard the held instruction and all pending busy bits with no issue.

Configuration
REQ-030 With macro SCOREBOARD_WB_BYPASS_EN defined, a same-cycle wb_valid release of a register SHALL be treated as not busy in the REQ-016 check.
REQ-031 Without SCOREBOARD_WB_BYPASS_EN, the check SHALL use only the registered busy table, so a released register becomes eligible one cycle after wb_valid.

Verification
REQ-032 Reset, then warp0 valid, wb=1, rd=5, rs=1,2,3, out_ready=1 -> in_ready=0001; next cycle out_valid=1, out_wis=0, busy[0][5]=1.
REQ-033 Warp0 rs1=5 while busy[0][5] set; pulse wb_valid with wis=0, rd=5 -> without the macro, in_ready[0] rises one cycle after the pulse; with the macro, in the same cycle.
REQ-034 All 4 warps eligible, out_ready=1 for 8 cycles -> grants in order 0,1,2,3,0,1,2,3; stall_cnt stays 0.
REQ-035 out_ready=0 with out_valid=1 and warps valid -> in_ready=0 and out_wis stable; stall_cnt increments by 1 per cycle.
REQ-036 Issue of rd=0 with wb=1 -> busy[w][0] stays 0; a later instruction with rs1=0 issues at once.
REQ-037 Assert reset while out_valid=1 and busy bits set -> out_valid=0, busy table zero and stall_cnt=0 after the reset edge.
